// File: rtl/bt_sched_pkg.sv
// Shared types and widths for the Bluetooth encoder scheduler.
// Holds the scheduler state encoding and the encoder port widths.
package bt_sched_pkg;

    localparam int BT_DATA_W = 33;
    localparam int BT_CMD_W  = 4;
    localparam int BT_OUT_W  = 128;
    localparam int SRC_W     = 3;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/bt_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_grant, wrapping to the lowest.
// The pointer register stays in the scheduler.
module bt_rr_arbiter
    import bt_sched_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic hi_found;
    logic lo_found;
    int   hi_idx;
    int   lo_idx;
    int   sel;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = 0;
        lo_idx   = 0;
        // Descending scans so the lowest matching index is the one left standing.
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j] && (j > int'(last_grant))) begin
                hi_idx   = j;
                hi_found = 1'b1;
            end
            if (req[j]) begin
                lo_idx   = j;
                lo_found = 1'b1;
            end
        end
        // Nothing above the pointer means the search wrapped: lowest set bit wins.
        sel         = hi_found ? hi_idx : lo_idx;
        grant_valid = lo_found;
        grant_idx   = SRC_W'(sel);
        grant       = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = lo_found && (sel == j);
        end
    end

endmodule

// File: rtl/bt_encoder_scheduler.sv
// Shares one Bluetooth encoder among NUM_REQ requesters: round-robin grant,
// start/done sequencing with timeout, and capture of the encoded word for transmit.
module bt_encoder_scheduler
    import bt_sched_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*BT_DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*BT_CMD_W-1:0]    req_cmd,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [BT_DATA_W-1:0]           enc_input_data,
    output logic [BT_CMD_W-1:0]            enc_command_select,
    output logic                           enc_start,
    input  logic                           enc_done,
    input  logic [BT_OUT_W-1:0]            enc_output_data,
    output logic [BT_OUT_W-1:0]            tx_data,
    output logic [SRC_W-1:0]               tx_src,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           timeout_err,
    output logic [1:0]                     state_dbg
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_t         state;
    sched_state_t         next_state;
    logic [SRC_W-1:0]     last_grant;
    logic [CNT_W-1:0]     wait_cnt;
    logic [NUM_REQ-1:0]   grant;
    logic [SRC_W-1:0]     grant_idx;
    logic                 grant_valid;
    logic                 load_grant;
    logic                 capture;
    logic [BT_DATA_W-1:0] sel_data;
    logic [BT_CMD_W-1:0]  sel_cmd;

    bt_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req         (req_valid),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_data = '0;
        sel_cmd  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data = req_data[i*BT_DATA_W +: BT_DATA_W];
                sel_cmd  = req_cmd[i*BT_CMD_W +: BT_CMD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshakes: req_ready is a one-cycle accept pulse, so the requester pops on
    // req_valid && req_ready; tx_valid holds with tx_data/tx_src stable until the
    // cycle tx_ready is seen high, and the transfer happens on tx_valid && tx_ready.
    always_comb begin
        next_state  = state;
        req_ready   = '0;
        enc_start   = 1'b0;
        timeout_err = 1'b0;
        load_grant  = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ready  = grant;
                    load_grant = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                enc_start  = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                // A late done landing on the final timeout cycle still counts.
                if (enc_done) begin
                    capture    = 1'b1;
                    next_state = OUT;
                end else if (wait_cnt == TO_LAST) begin
                    timeout_err = 1'b1;
                    next_state  = IDLE;
                end
            end
            OUT: begin
                if (tx_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enc_input_data     <= '0;
            enc_command_select <= '0;
            tx_src             <= '0;
            last_grant         <= SRC_W'(NUM_REQ - 1);
            wait_cnt           <= '0;
            tx_data            <= '0;
        end else begin
            if (load_grant) begin
                enc_input_data     <= sel_data;
                enc_command_select <= sel_cmd;
                tx_src             <= grant_idx;
                last_grant         <= grant_idx;
            end
            if (enc_start) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (capture) begin
                tx_data <= enc_output_data;
            end
        end
    end

    assign tx_valid  = (state == OUT);
    assign state_dbg = state;

endmodule

// File: tb/tb_bt_encoder_scheduler.sv
// Directed bench for bt_encoder_scheduler: the bench plays the encoder, pushes the
// expected {src, word} when it answers, and pops/compares when tx_valid appears.
module tb_bt_encoder_scheduler;
    import bt_sched_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N-1:0]           req_valid;
    logic [N*BT_DATA_W-1:0] req_data;
    logic [N*BT_CMD_W-1:0]  req_cmd;
    logic [N-1:0]           req_ready;
    logic [BT_DATA_W-1:0]   enc_input_data;
    logic [BT_CMD_W-1:0]    enc_command_select;
    logic                   enc_start;
    logic                   enc_done;
    logic [BT_OUT_W-1:0]    enc_output_data;
    logic [BT_OUT_W-1:0]    tx_data;
    logic [SRC_W-1:0]       tx_src;
    logic                   tx_valid;
    logic                   tx_ready;
    logic                   timeout_err;
    logic [1:0]             state_dbg;

    int checks = 0;
    int errors = 0;
    logic [SRC_W+BT_OUT_W-1:0] exp_q[$];
    logic [BT_DATA_W-1:0] rd[N];
    logic [BT_CMD_W-1:0]  rc[N];

    bt_encoder_scheduler #(
        .NUM_REQ (N),
        .TIMEOUT (TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_data           (req_data),
        .req_cmd            (req_cmd),
        .req_ready          (req_ready),
        .enc_input_data     (enc_input_data),
        .enc_command_select (enc_command_select),
        .enc_start          (enc_start),
        .enc_done           (enc_done),
        .enc_output_data    (enc_output_data),
        .tx_data            (tx_data),
        .tx_src             (tx_src),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .timeout_err        (timeout_err),
        .state_dbg          (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic new_payload();
        for (int i = 0; i < N; i++) begin
            rd[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
            rc[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic drive_reqs(input logic [N-1:0] v);
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_data[i*BT_DATA_W +: BT_DATA_W] = rd[i];
            req_cmd[i*BT_CMD_W +: BT_CMD_W]    = rc[i];
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, req_ready, '0);
        chk({tag, "_enc_data"}, enc_input_data, '0);
        chk({tag, "_enc_cmd"}, enc_command_select, '0);
        chk({tag, "_enc_start"}, enc_start, 0);
        chk({tag, "_tx_data"}, tx_data, '0);
        chk({tag, "_tx_src"}, tx_src, '0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_state"}, state_dbg, IDLE);
    endtask

    // Entered at the checkpoint of the grant cycle; leaves at the checkpoint of the
    // IDLE cycle after tx_ready. req_valid becomes next_valid from cycle 1 onward.
    task automatic txn(input int src, input int lat, input int hold,
                       input logic [N-1:0] next_valid, input logic [127:0] word);
        logic [N-1:0]              onehot;
        logic [SRC_W+BT_OUT_W-1:0] e;
        onehot = N'(1) << src;
        chk("grant_onehot", req_ready, onehot);
        next();
        req_valid = next_valid;
        settle();
        chk("start_pulse", enc_start, 1);
        chk("ready_one_cycle", req_ready, '0);
        chk("enc_data", enc_input_data, rd[src]);
        chk("enc_cmd", enc_command_select, rc[src]);
        for (int i = 1; i < lat; i++) begin
            next();
            settle();
            chk("start_low", enc_start, 0);
            chk("wait_no_valid", tx_valid, 0);
        end
        next();
        enc_done        = 1'b1;
        enc_output_data = word;
        exp_q.push_back({3'(src), word});
        settle();
        chk("done_no_timeout", timeout_err, 0);
        chk("valid_not_early", tx_valid, 0);
        next();
        enc_done        = 1'b0;
        enc_output_data = {$urandom, $urandom, $urandom, $urandom};
        tx_ready        = (hold == 0);
        settle();
        chk("tx_valid_rise", tx_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("tx_data", tx_data, e[BT_OUT_W-1:0]);
        chk("tx_src", tx_src, e[SRC_W+BT_OUT_W-1:BT_OUT_W]);
        for (int h = 1; h <= hold; h++) begin
            next();
            tx_ready = (h == hold);
            settle();
            chk("hold_valid", tx_valid, 1);
            chk("hold_data", tx_data, e[BT_OUT_W-1:0]);
            chk("hold_src", tx_src, e[SRC_W+BT_OUT_W-1:BT_OUT_W]);
            chk("hold_no_grant", req_ready, '0);
        end
        next();
        tx_ready = 1'b0;
        settle();
        chk("idle_after_ready", state_dbg, IDLE);
        chk("valid_dropped", tx_valid, 0);
    endtask

    initial begin
        reset           = 1'b0;
        enc_done        = 1'b0;
        enc_output_data = '0;
        tx_ready        = 1'b0;
        new_payload();
        drive_reqs('0);

        // Reset state
        repeat (2) next();
        settle();
        chk_quiet("reset");
        next();
        reset = 1'b1;
        settle();

        // Round-robin with all requesters held
        next();
        drive_reqs(3'b111);
        settle();
        txn(0, 2, 0, 3'b111, {$urandom, $urandom, $urandom, $urandom});
        txn(1, 2, 0, 3'b111, {$urandom, $urandom, $urandom, $urandom});
        txn(2, 2, 0, 3'b111, {$urandom, $urandom, $urandom, $urandom});
        txn(0, 2, 0, 3'b000, {$urandom, $urandom, $urandom, $urandom});

        // Single request from requester 1, encoder answers 5 cycles after start
        new_payload();
        rd[1] = 33'h012345678;
        rc[1] = 4'h1;
        drive_reqs(3'b010);
        settle();
        txn(1, 5, 0, 3'b000, {16{8'hA5}});

        // Backpressure with another requester waiting
        new_payload();
        drive_reqs(3'b101);
        settle();
        txn(2, 3, 10, 3'b101, {$urandom, $urandom, $urandom, $urandom});
        txn(0, 3, 0, 3'b000, {$urandom, $urandom, $urandom, $urandom});

        // Timeout: encoder silent, then next requester granted
        new_payload();
        drive_reqs(3'b110);
        settle();
        chk("to_grant", req_ready, 3'b010);
        next();
        settle();
        chk("to_start", enc_start, 1);
        for (int c = 2; c <= TO; c++) begin
            next();
            settle();
            chk("to_quiet", timeout_err, 0);
        end
        next();
        settle();
        chk("timeout_pulse", timeout_err, 1);
        chk("timeout_no_valid", tx_valid, 0);
        next();
        settle();
        chk("timeout_one_cycle", timeout_err, 0);
        chk("timeout_no_valid_after", tx_valid, 0);
        // Done lands on the timeout cycle: output wins, no error
        txn(2, TO, 0, 3'b000, {$urandom, $urandom, $urandom, $urandom});

        // Done while idle is ignored
        enc_done        = 1'b1;
        enc_output_data = {$urandom, $urandom, $urandom, $urandom};
        settle();
        chk("idle_done_state", state_dbg, IDLE);
        next();
        settle();
        chk("idle_done_no_valid", tx_valid, 0);
        chk("idle_done_no_start", enc_start, 0);
        chk("idle_done_state2", state_dbg, IDLE);
        next();
        enc_done = 1'b0;
        settle();
        chk("idle_done_no_valid2", tx_valid, 0);

        // Reset mid-WAIT after granting requester 0
        new_payload();
        rd[0][0] = 1'b1;
        drive_reqs(3'b001);
        settle();
        chk("rst_pre_grant", req_ready, 3'b001);
        next();
        drive_reqs('0);
        settle();
        next();
        settle();
        chk("rst_in_wait", state_dbg, WAIT);
        next();
        reset = 1'b0;
        settle();
        chk_quiet("rst_mid_wait");
        next();
        reset = 1'b1;
        new_payload();
        drive_reqs(3'b111);
        settle();
        chk("prio_after_reset", req_ready, 3'b001);
        txn(0, 2, 0, 3'b000, {$urandom, $urandom, $urandom, $urandom});

        chk("scoreboard_empty", 128'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bt_encoder_scheduler.md
# bt_encoder_scheduler

Shares one `bluetooth_encoder` instance among `NUM_REQ` requesters (host command path, sensor sampler, link-status reporter). Round-robin arbitration, `start`/`done` sequencing with a timeout, and capture of the 128-bit encoded word. Output goes to the radio transmit stage over a valid/ready handshake. Sits between the requester FIFOs and the encoder; the encoder's ports connect directly to the `enc_*` ports.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `TIMEOUT`, 255: maximum WAIT cycles for `enc_done`, 1..65535.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req_valid`  in  NUM_REQ  per-requester request pending.
- `req_data`  in  NUM_REQ*33  payload; requester i occupies bits [33i+32:33i].
- `req_cmd`  in  NUM_REQ*4  command select; requester i occupies bits [4i+3:4i].
- `req_ready`  out  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester.
- `enc_input_data`  out  33  registered payload to the encoder.
- `enc_command_select`  out  4  registered command to the encoder.
- `enc_start`  out  1  one-cycle start pulse.
- `enc_done`  in  1  encoder completion; `enc_output_data` is valid in the same cycle.
- `enc_output_data`  in  128  encoded word.
- `tx_data`  out  128  captured encoded word.
- `tx_src`  out  3  index of the requester that produced `tx_data`.
- `tx_valid`  out  1  `tx_data` available.
- `tx_ready`  in  1  transmit stage accepts.
- `timeout_err`  out  1  one-cycle pulse when the encoder fails to respond.

## Operation
- FSM states: IDLE, START, WAIT, OUT.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit searching upward from `last_grant+1`, wrapping modulo `NUM_REQ`.
  - Pulse `req_ready[g]`, latch `req_data`/`req_cmd` slice g into `enc_input_data`/`enc_command_select`, record `tx_src=g`, set `last_grant=g`, go to START.
- **START**
  - `enc_start=1` for exactly this cycle.
  - Clear the timeout counter, go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - If `enc_done`=1: register `enc_output_data` into `tx_data`, go to OUT.
  - Else if counter == `TIMEOUT-1`: pulse `timeout_err`, go to IDLE. No `tx_valid` is raised and the request is dropped.
  - `enc_done` and the timeout in the same cycle: `enc_done` wins.
- **OUT**
  - `tx_valid=1`; `tx_data` and `tx_src` hold stable until `tx_ready`=1.
  - On `tx_ready`=1, go to IDLE.
- `enc_done` outside WAIT is ignored.
- `enc_input_data` and `enc_command_select` hold from START until the next grant.
- `req_valid` deasserting after its grant has no effect.
- Only one request is in flight at a time; requesters are never granted while the scheduler is not in IDLE.

## Timing
- Reset values:
  - state=IDLE, `last_grant=NUM_REQ-1`, so requester 0 has first priority.
  - All outputs 0: `req_ready`, `enc_*`, `tx_data`, `tx_src`, `tx_valid`, `timeout_err`.
- Reset asserted mid-operation returns to IDLE immediately. A pending `tx_valid` drops and the captured word is lost.
- Latency:
  - Grant in cycle 0.
  - `enc_start` in cycle 1.
  - If `enc_done` is sampled in cycle k, `tx_valid` rises in cycle k+1.
  - IDLE is re-entered in the cycle after `tx_ready`, so the minimum request-to-request spacing is 4 cycles plus encoder latency.
- `tx_valid` never deasserts without `tx_ready`.
- Timeout fires TIMEOUT cycles after `enc_start`.

## Structure
- Package `bt_sched_pkg` holds:
  - the state enum;
  - `BT_DATA_W=33`, `BT_CMD_W=4`, `BT_OUT_W=128`;
  - the `SRC_W=3` constant.
- Sub-module `bt_rr_arbiter`: `req` vector and `last_grant` in; one-hot grant and encoded index out. Combinational rotate-and-priority logic; the pointer register stays in the top level.

## Test plan
- Single request:
  - Stimulus: after reset, req1 valid with data 33'h012345678, cmd 4'h1; `enc_done` returns after 5 cycles with 128'hA5..A5; `tx_ready`=1.
  - Response: `req_ready`=3'b010 in cycle 0; `enc_start` in cycle 1; `tx_valid` in cycle 7 with `tx_src`=1.
- Round-robin:
  - Stimulus: all three requesters held valid; encoder answers in 2 cycles.
  - Response: grant order is 0,1,2,0; each `req_ready` is one-hot and lasts one cycle.
- Backpressure:
  - Stimulus: `tx_ready`=0 for 10 cycles after `tx_valid`.
  - Response: `tx_data`/`tx_src` stable throughout, no new grant; IDLE in the cycle after `tx_ready`=1.
- Timeout:
  - Stimulus: TIMEOUT=8 and `enc_done` is never asserted.
  - Response: `timeout_err` pulses 8 cycles after `enc_start`, then the next requester is granted; `tx_valid` stays 0.
- Simultaneous events:
  - Stimulus: `enc_done` arrives in the timeout cycle; separately, `enc_done` arrives while in IDLE.
  - Response: the first yields output and no error; the second is ignored.
- Reset mid-WAIT:
  - Stimulus: `reset`=0 for 1 cycle while in WAIT, then released.
  - Response: all outputs 0 and requester 0 has priority on the next grant.
